// File: rtl/go_board_cpu_top.sv
// Go Board educational CPU: debounced buttons, 4-bit PC, A/B registers, two program ROMs,
// and a selected nibble shown on LEDs and on two active-low 7-segment digits.
module go_board_cpu_top #(
  parameter int unsigned DEBOUNCE_LIMIT = 250000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic SW1,
  input  logic SW2,
  input  logic SW3,
  input  logic SW4,
  output logic LED1,
  output logic LED2,
  output logic LED3,
  output logic LED4,
  output logic o_Segment1_A,
  output logic o_Segment1_B,
  output logic o_Segment1_C,
  output logic o_Segment1_D,
  output logic o_Segment1_E,
  output logic o_Segment1_F,
  output logic o_Segment1_G,
  output logic o_Segment2_A,
  output logic o_Segment2_B,
  output logic o_Segment2_C,
  output logic o_Segment2_D,
  output logic o_Segment2_E,
  output logic o_Segment2_F,
  output logic o_Segment2_G
);

  localparam int unsigned NBTN  = 4;
  localparam int unsigned CNT_W = (DEBOUNCE_LIMIT < 2) ? 1 : $clog2(DEBOUNCE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);
  localparam logic [6:0] SEG_ZERO = 7'b0000001;

  function automatic logic [7:0] rom_f(input logic bank, input logic [3:0] pc);
    logic [7:0] r;
    r = 8'h00;
    case ({bank, pc})
      5'h00: r = 8'h13;
      5'h01: r = 8'h25;
      5'h02: r = 8'h30;
      5'h03: r = 8'h40;
      5'h04: r = 8'hB0;
      5'h05: r = 8'h90;
      5'h06: r = 8'h50;
      5'h07: r = 8'h60;
      5'h0F: r = 8'hD0;
      5'h10: r = 8'h1F;
      5'h11: r = 8'h21;
      5'h12: r = 8'h40;
      5'h13: r = 8'hD2;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic writes_a_f(input logic [3:0] op);
    return (op == 4'h1) || ((op >= 4'h3) && (op <= 4'hB));
  endfunction

  // Value the instruction would write to A; A+B for instructions that leave A alone.
  function automatic logic [7:0] alu_f(input logic [7:0] instr, input logic [7:0] a,
                                       input logic [7:0] b);
    logic [7:0] r;
    case (instr[7:4])
      4'h1:    r = {4'h0, instr[3:0]};
      4'h3:    r = a + b;
      4'h4:    r = a - b;
      4'h5:    r = a & b;
      4'h6:    r = a | b;
      4'h7:    r = a ^ b;
      4'h8:    r = ~a;
      4'h9:    r = {a[6:0], 1'b0};
      4'hA:    r = {1'b0, a[7:1]};
      4'hB:    r = a + 8'd1;
      default: r = a + b;
    endcase
    return r;
  endfunction

  // Display only needs the low ALU nibble; right shift pulls in A[4].
  function automatic logic [3:0] alu_lo_f(input logic [7:0] instr, input logic [4:0] a,
                                          input logic [3:0] b);
    logic [3:0] r;
    case (instr[7:4])
      4'h1:    r = instr[3:0];
      4'h3:    r = a[3:0] + b;
      4'h4:    r = a[3:0] - b;
      4'h5:    r = a[3:0] & b;
      4'h6:    r = a[3:0] | b;
      4'h7:    r = a[3:0] ^ b;
      4'h8:    r = ~a[3:0];
      4'h9:    r = {a[2:0], 1'b0};
      4'hA:    r = a[4:1];
      4'hB:    r = a[3:0] + 4'd1;
      default: r = a[3:0] + b;
    endcase
    return r;
  endfunction

  function automatic logic [6:0] seg_f(input logic [3:0] d);
    logic [6:0] r;
    case (d)
      4'd0:    r = 7'b0000001;
      4'd1:    r = 7'b1001111;
      4'd2:    r = 7'b0010010;
      4'd3:    r = 7'b0000110;
      4'd4:    r = 7'b1001100;
      4'd5:    r = 7'b0100100;
      4'd6:    r = 7'b0100000;
      4'd7:    r = 7'b0001111;
      4'd8:    r = 7'b0000000;
      4'd9:    r = 7'b0000100;
      default: r = 7'b1111111;
    endcase
    return r;
  endfunction

  logic [NBTN-1:0]  raw_press;
  logic [NBTN-1:0]  sync1_q, sync2_q;
  logic [NBTN-1:0]  level_q, prev_q;
  logic [CNT_W-1:0] cnt_q [NBTN];
  logic [NBTN-1:0]  press_ev;

  // Button bit 0..3 = SW1..SW4, normalised so 1 means pressed.
  assign raw_press = {~SW4, ~SW3, ~SW2, SW1};
  assign press_ev  = level_q & ~prev_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      prev_q  <= '0;
      for (int i = 0; i < NBTN; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= raw_press;
      sync2_q <= sync1_q;
      prev_q  <= level_q;
      for (int i = 0; i < NBTN; i++) begin
        if (sync2_q[i] != level_q[i]) begin
          if (cnt_q[i] == CNT_LAST) begin
            level_q[i] <= sync2_q[i];
            cnt_q[i]   <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + CNT_W'(1);
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  logic [3:0] pc_q, pc_d;
  logic [7:0] a_q, a_d, b_q, b_d;
  logic [1:0] mode_q, mode_d;
  logic       bank_q, bank_d;
  logic [7:0] cur_instr, cur_alu;

  assign cur_instr = rom_f(bank_q, pc_q);
  assign cur_alu   = alu_f(cur_instr, a_q, b_q);

  // One button acts per clock: clear, step, mode, bank in priority order.
  always_comb begin
    pc_d   = pc_q;
    a_d    = a_q;
    b_d    = b_q;
    mode_d = mode_q;
    bank_d = bank_q;
    if (press_ev[0]) begin
      pc_d = '0;
      a_d  = '0;
      b_d  = '0;
    end else if (press_ev[1]) begin
      if (!level_q[0]) begin
        if (writes_a_f(cur_instr[7:4])) a_d = cur_alu;
        if (cur_instr[7:4] == 4'h2) b_d = {4'h0, cur_instr[3:0]};
        if (cur_instr[7:4] == 4'hC) b_d = a_q;
        pc_d = (cur_instr[7:4] == 4'hD) ? cur_instr[3:0] : pc_q + 4'd1;
      end
    end else if (press_ev[2]) begin
      mode_d = mode_q + 2'd1;
    end else if (press_ev[3]) begin
      bank_d = ~bank_q;
      pc_d   = '0;
    end
  end

  logic [7:0] nxt_instr;
  logic [3:0] sel, ones;
  logic       tens;
  logic [3:0] led_q;
  logic [6:0] seg1_q, seg2_q;

  // Display is derived from next state so it changes on the same edge as the state.
  always_comb begin
    nxt_instr = rom_f(bank_d, pc_d);
    case (mode_d)
      2'd0:    sel = pc_d;
      2'd1:    sel = a_d[3:0];
      2'd2:    sel = b_d[3:0];
      default: sel = alu_lo_f(nxt_instr, a_d[4:0], b_d[3:0]);
    endcase
    tens = (sel >= 4'd10);
    ones = tens ? sel - 4'd10 : sel;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= '0;
      bank_q <= 1'b0;
      led_q  <= '0;
      seg1_q <= SEG_ZERO;
      seg2_q <= SEG_ZERO;
    end else begin
      pc_q   <= pc_d;
      a_q    <= a_d;
      b_q    <= b_d;
      mode_q <= mode_d;
      bank_q <= bank_d;
      led_q  <= sel;
      seg1_q <= seg_f({3'b000, tens});
      seg2_q <= seg_f(ones);
    end
  end

  assign {LED1, LED2, LED3, LED4} = led_q;
  assign {o_Segment1_A, o_Segment1_B, o_Segment1_C, o_Segment1_D,
          o_Segment1_E, o_Segment1_F, o_Segment1_G} = seg1_q;
  assign {o_Segment2_A, o_Segment2_B, o_Segment2_C, o_Segment2_D,
          o_Segment2_E, o_Segment2_F, o_Segment2_G} = seg2_q;

endmodule

// File: tb/tb_go_board_cpu_top.sv
// Bench for go_board_cpu_top: button-level stimulus, a behavioural CPU model and a
// scoreboard queue of expected display outputs consumed by an independent monitor.
module tb_go_board_cpu_top;

  localparam int unsigned LIM = 5;
  localparam int HOLD = 3 * LIM;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sw1 = 1'b0, sw2 = 1'b1, sw3 = 1'b1, sw4 = 1'b1;
  logic led1, led2, led3, led4;
  logic s1a, s1b, s1c, s1d, s1e, s1f, s1g;
  logic s2a, s2b, s2c, s2d, s2e, s2f, s2g;

  go_board_cpu_top #(.DEBOUNCE_LIMIT(LIM)) dut (
    .CLK(clk), .RST_N(rst_n),
    .SW1(sw1), .SW2(sw2), .SW3(sw3), .SW4(sw4),
    .LED1(led1), .LED2(led2), .LED3(led3), .LED4(led4),
    .o_Segment1_A(s1a), .o_Segment1_B(s1b), .o_Segment1_C(s1c), .o_Segment1_D(s1d),
    .o_Segment1_E(s1e), .o_Segment1_F(s1f), .o_Segment1_G(s1g),
    .o_Segment2_A(s2a), .o_Segment2_B(s2b), .o_Segment2_C(s2c), .o_Segment2_D(s2d),
    .o_Segment2_E(s2e), .o_Segment2_F(s2f), .o_Segment2_G(s2g)
  );

  always #5 clk = ~clk;

  int m_pc, m_a, m_b, m_mode, m_bank;
  int rom0 [16];
  int rom1 [16];

  logic [17:0] exp_q [$];
  string       name_q [$];
  int checks = 0;
  int errors = 0;

  function automatic int instr_at();
    return (m_bank != 0) ? rom1[m_pc] : rom0[m_pc];
  endfunction

  // New A value for an instruction, or -1 when the instruction leaves A unchanged.
  function automatic int new_a(int instr, int a, int b);
    int op, imm;
    op  = instr / 16;
    imm = instr % 16;
    case (op)
      1:  return imm;
      3:  return (a + b) % 256;
      4:  return (a - b + 256) % 256;
      5:  return a & b;
      6:  return a | b;
      7:  return a ^ b;
      8:  return 255 - a;
      9:  return (a * 2) % 256;
      10: return a / 2;
      11: return (a + 1) % 256;
      default: return -1;
    endcase
  endfunction

  function automatic int disp_val();
    int na;
    na = new_a(instr_at(), m_a, m_b);
    case (m_mode)
      0: return m_pc;
      1: return m_a % 16;
      2: return m_b % 16;
      default: return ((na >= 0) ? na : (m_a + m_b) % 256) % 16;
    endcase
  endfunction

  function automatic logic [6:0] seg_of(int d);
    string s;
    logic [6:0] r;
    int idx;
    case (d)
      0: s = "abcdef";
      1: s = "bc";
      2: s = "abdeg";
      3: s = "abcdg";
      4: s = "bcfg";
      5: s = "acdfg";
      6: s = "acdefg";
      7: s = "abc";
      8: s = "abcdefg";
      default: s = "abcdfg";
    endcase
    r = 7'h7f;
    for (int i = 0; i < s.len(); i++) begin
      idx = 6 - (int'(s[i]) - 97);
      r[idx] = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [17:0] pack_of(int v);
    return {4'(v), seg_of(v / 10), seg_of(v % 10)};
  endfunction

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_btn(int b, bit pressed);
    case (b)
      1: sw1 = pressed;
      2: sw2 = ~pressed;
      3: sw3 = ~pressed;
      default: sw4 = ~pressed;
    endcase
  endtask

  task automatic press(int b, int hold);
    set_btn(b, 1'b1);
    tick(hold);
    set_btn(b, 1'b0);
    tick(HOLD);
  endtask

  task automatic expect_val(int v, string nm);
    exp_q.push_back(pack_of(v));
    name_q.push_back(nm);
    tick(2);
  endtask

  task automatic expect_model(string nm);
    expect_val(disp_val(), nm);
  endtask

  task automatic model_step();
    int instr, na, op;
    instr = instr_at();
    op = instr / 16;
    na = new_a(instr, m_a, m_b);
    if (op == 2) m_b = instr % 16;
    if (op == 12) m_b = m_a;
    if (na >= 0) m_a = na;
    m_pc = (op == 13) ? instr % 16 : (m_pc + 1) % 16;
  endtask

  task automatic do_step();
    press(2, HOLD);
    model_step();
  endtask

  task automatic do_long_step();
    press(2, 8 * LIM);
    model_step();
  endtask

  task automatic do_mode();
    press(3, HOLD);
    m_mode = (m_mode + 1) % 4;
  endtask

  task automatic do_bank();
    press(4, HOLD);
    m_bank = 1 - m_bank;
    m_pc = 0;
  endtask

  task automatic do_clear();
    press(1, HOLD);
    m_pc = 0; m_a = 0; m_b = 0;
  endtask

  // SW1 held while SW2 is pressed: the clear acts, the step must not.
  task automatic do_clear_held_step();
    set_btn(1, 1'b1);
    tick(HOLD);
    press(2, HOLD);
    set_btn(1, 1'b0);
    tick(HOLD);
    m_pc = 0; m_a = 0; m_b = 0;
  endtask

  task automatic do_glitch(int b);
    press(b, LIM - 2);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    m_pc = 0; m_a = 0; m_b = 0; m_mode = 0; m_bank = 0;
    exp_q.push_back(pack_of(0));
    name_q.push_back("reset_hold");
    tick(2);
    rst_n = 1'b1;
    tick(2);
  endtask

  // Scoreboard monitor: compares queued expectations against the outputs at the falling edge.
  initial begin
    logic [17:0] e, act;
    string nm;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        act = {led1, led2, led3, led4, s1a, s1b, s1c, s1d, s1e, s1f, s1g,
               s2a, s2b, s2c, s2d, s2e, s2f, s2g};
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL %s: got led=%b seg1=%b seg2=%b, expected led=%b seg1=%b seg2=%b",
                   nm, act[17:14], act[13:7], act[6:0], e[17:14], e[13:7], e[6:0]);
        end
      end
    end
  end

  initial begin
    int r, wait_cnt;
    rom0 = '{8'h13, 8'h25, 8'h30, 8'h40, 8'hB0, 8'h90, 8'h50, 8'h60,
             0, 0, 0, 0, 0, 0, 0, 8'hD0};
    rom1 = '{8'h1F, 8'h21, 8'h40, 8'hD2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    m_pc = 0; m_a = 0; m_b = 0; m_mode = 0; m_bank = 0;

    exp_q.push_back(pack_of(0));
    name_q.push_back("reset_hold");
    tick(2);
    rst_n = 1'b1;
    tick(3);
    expect_val(0, "reset");

    do_clear();       expect_val(0, "clear_from_reset");
    do_glitch(1);     expect_val(0, "short_sw1");
    do_step();        expect_val(1, "step1_pc");
    do_step();        expect_val(2, "step2_pc");
    do_glitch(2);     expect_val(2, "short_sw2");
    do_step();        expect_val(3, "step3_pc");
    do_mode();        expect_val(8, "mode1_a");
    do_mode();        expect_val(5, "mode2_b");
    do_mode();        expect_val(3, "mode3_alu");
    do_mode();        expect_val(3, "mode0_pc");
    do_step();        expect_val(4, "step4_pc");
    do_mode();        expect_val(3, "pc4_a");
    do_mode();        expect_val(5, "pc4_b");
    do_mode();        expect_val(4, "pc4_alu");
    do_mode();        expect_val(4, "pc4_mode0");
    for (int i = 5; i <= 15; i++) begin
      do_step();
      expect_val(i, $sformatf("walk_pc%0d", i));
    end
    do_step();        expect_val(0, "jump_wrap");
    do_long_step();   expect_val(1, "long_hold_one_step");
    do_bank();        expect_val(0, "bank1_pc0");
    do_step();        expect_val(1, "b1_step1");
    do_step();        expect_val(2, "b1_step2");
    do_step();        expect_val(3, "b1_step3");
    do_step();        expect_val(2, "b1_loop_jump");
    do_step();        expect_val(3, "b1_step5");
    do_step();        expect_val(2, "b1_step6");
    do_mode();        expect_val(13, "b1_a");
    do_mode();        expect_val(1, "b1_b");
    do_mode();        expect_val(12, "b1_alu");
    do_mode();        expect_val(2, "b1_mode0");
    do_bank();        expect_val(0, "bank0_pc0");
    repeat (12) do_step();
    expect_val(12, "pc12_digits");
    do_clear_held_step(); expect_val(0, "held_sw1_blocks_step");

    for (int k = 0; k < 90; k++) begin
      r = $urandom_range(0, 99);
      if (r < 48)      begin do_step();  expect_model($sformatf("rand%0d_step", k)); end
      else if (r < 64) begin do_mode();  expect_model($sformatf("rand%0d_mode", k)); end
      else if (r < 72) begin do_bank();  expect_model($sformatf("rand%0d_bank", k)); end
      else if (r < 78) begin do_clear(); expect_model($sformatf("rand%0d_clear", k)); end
      else if (r < 88) begin
        do_glitch($urandom_range(1, 4));
        expect_model($sformatf("rand%0d_glitch", k));
      end else if (r < 92) begin do_long_step(); expect_model($sformatf("rand%0d_long", k)); end
      else if (r < 96) begin do_clear_held_step(); expect_model($sformatf("rand%0d_held", k)); end
      else begin do_reset(); expect_model($sformatf("rand%0d_reset", k)); end
    end

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 20) begin
      tick(1);
      wait_cnt++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/go_board_cpu_top.md
Name: go_board_cpu_top

Overview:
- Top level of a small educational 8-bit CPU on the Go Board FPGA: debounced buttons drive reset, single-step, display-mode select and program-bank select.
- Contents: 4-bit PC, two 8-bit registers (A, B), combinational ALU and two 16-word instruction ROMs.
- A selected internal value is shown on 4 LEDs and, as a decimal number, on two active-low 7-segment digits.

Parameters:
- DEBOUNCE_LIMIT, 250000: consecutive stable clocks required before a button change is accepted (5 in simulation builds).

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low system reset.
- SW1  in  1  CPU-clear button, active-high.
- SW2  in  1  step button, active-low.
- SW3  in  1  display-mode button, active-low.
- SW4  in  1  program-bank button, active-low.
- LED1..LED4  out  1 each  selected value bits 3..0 (LED1 = bit 3), active-high.
- o_Segment1_A..G  out  1 each  tens digit, active-low segments.
- o_Segment2_A..G  out  1 each  ones digit, active-low segments.

Behaviour:
- RST_N low (asynchronous): PC=0, A=0, B=0, display_mode=0, bank=0, all debouncers cleared.
- Outputs during reset: LEDs 0000; both digits show "0".
- Debounce, per button: the filtered level updates only after the raw input has held a new value for DEBOUNCE_LIMIT consecutive clocks. Action events are generated on the filtered press edge only, as a 1-clock pulse.
- SW1 press (debounced rising level): PC=0, A=0, B=0 on the next clock. Display mode and bank are kept. While SW1 is held, step events are ignored.
- SW2 press: executes exactly one instruction. Holding the button gives no further steps; the next step needs a release and a new press.
- SW3 press: display_mode increments mod 4, wrapping 3 -> 0.
  - Modes: 0 = PC, 1 = A[3:0], 2 = B[3:0], 3 = ALU[3:0].
- SW4 press: bank toggles, and PC=0 on the same clock; A and B are kept.
- Instruction format: 8 bits; op = [7:4], imm = [3:0].
- Opcodes:
  - 0 NOP
  - 1 A=imm
  - 2 B=imm
  - 3 A=A+B
  - 4 A=A-B
  - 5 A=A&B
  - 6 A=A|B
  - 7 A=A^B
  - 8 A=~A
  - 9 A=A<<1
  - A A=A>>1 (logical)
  - B A=A+1
  - C B=A
  - D PC=imm (jump)
  - E, F: NOP
- Arithmetic is 8-bit modulo 256, with no flags.
- PC=PC+1 mod 16 after every non-jump step.
- ALU output is combinational: the result the current instruction at PC would write to A, from the current A and B. For opcodes that do not write A, it is A+B.
- Bank 0 ROM:
  - 0: 1_3
  - 1: 2_5
  - 2: 3_0
  - 3: 4_0
  - 4: B_0
  - 5: 9_0
  - 6: 5_0
  - 7: 6_0
  - 8-14: 0_0
  - 15: D_0
- Bank 1 ROM:
  - 0: 1_F
  - 1: 2_1
  - 2: 4_0
  - 3: D_2
  - 4-15: 0_0
- Display value v = selected 4-bit value (0-15).
  - tens = 1 if v >= 10, else 0; ones = v mod 10.
  - Both digits are always lit, with no leading-zero blanking.
- Segment patterns use standard a-g encoding, 0 = segment on.
  - "0": a-f on, g off.
  - "1": b, c on.
- A button event and an RST_N assertion in the same cycle: reset wins.
- Only one button acts per clock; SW1 has priority over SW2.
- Display outputs are a pure function of registered state; there is no extra latency beyond the state update.

Test Plan:
- RST_N low then high, no presses -> PC=0, A=00, B=00, mode 0, LEDs 0000, digits "00".
- SW1 pressed >DEBOUNCE_LIMIT clocks then released -> PC=0, A=00, B=00. A press shorter than DEBOUNCE_LIMIT clocks has no effect.
- Three SW2 presses from reset -> PC=1/A=03/B=00, PC=2/B=05, PC=3/A=08; ALU at PC=3 is 03.
- SW3 pressed 4 times at PC=3, A=08, B=05, ALU=03:
  - after press 1 -> LEDs 1000, digits "08";
  - after press 2 -> LEDs 0101, digits "05";
  - after press 3 -> LEDs 0011, digits "03";
  - after press 4 -> mode 0, LEDs 0011.
- Fourth SW2 step -> PC=4, A=03, ALU=04. Then 4 SW3 presses -> mode 0, LEDs 0100, digits "04". Stepping to PC=15 and once more -> PC=0 (jump).
- SW4 press -> bank 1, PC=0. Steps -> A=0F, B=01, A=0E, PC=3, then PC=2 (loop). Mode-0 display with PC=12 shows digits "12".
